// File: rtl/status_frame_rx_if.sv
// Byte stream from the UART receiver and the decoded frame result.
// master: the UART/host side; slave: the status frame receiver.
interface status_frame_rx_if #(
  parameter int PAYLOAD_BYTES = 24
);
  logic                         rx_data_ready;
  logic [7:0]                   rx_data;
  logic                         frame_valid;
  logic [7:0]                   frame_motor;
  logic [PAYLOAD_BYTES*8-1:0]   frame_payload;

  modport master (
    output rx_data_ready, rx_data,
    input  frame_valid, frame_motor, frame_payload
  );

  modport slave (
    input  rx_data_ready, rx_data,
    output frame_valid, frame_motor, frame_payload
  );
endinterface

// File: rtl/status_frame_rx.sv
// Status frame receiver: hunts for a 32-bit magic word in the UART byte
// stream, collects motor ID + payload + CRC-16 (poly 0x8005, init FFFF,
// MSB first), then validates the frame and updates per-motor error codes
// and saturating event counters.
// Optional feature: define STATUS_RX_TIMEOUT_EN to abandon a frame when the
// gap between bytes exceeds TIMEOUT_BYTES character times.
module status_frame_rx #(
  parameter int          NUMBER_OF_MOTORS = 6,
  parameter int          PAYLOAD_BYTES    = 24,
  parameter logic [31:0] MAGIC_NUMBER     = 32'h1CEB00DA,
  parameter int          CLK_FREQ_HZ      = 50_000_000,
  parameter int          BAUDRATE         = 115200,
  parameter int          TIMEOUT_BYTES    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  status_frame_rx_if.slave              bus,
  output logic [NUMBER_OF_MOTORS*8-1:0] error_code,
  output logic [15:0]                   ok_count,
  output logic [15:0]                   crc_err_count,
  output logic [15:0]                   id_err_count,
  output logic [15:0]                   timeout_count
);

  localparam int PW = PAYLOAD_BYTES * 8;
  localparam int EW = NUMBER_OF_MOTORS * 8;
  localparam logic [6:0] IDX_LAST_PAY = 7'(PAYLOAD_BYTES);
  localparam logic [6:0] IDX_CRC_HI   = 7'(PAYLOAD_BYTES + 1);

  localparam logic [7:0] CODE_OK      = 8'd0;
  localparam logic [7:0] CODE_CRC     = 8'd2;

  // Reject parameter sets the datapath widths cannot represent.
  if (NUMBER_OF_MOTORS < 1 || NUMBER_OF_MOTORS > 255 ||
      PAYLOAD_BYTES < 1 || PAYLOAD_BYTES > 64 ||
      BAUDRATE < 1 || CLK_FREQ_HZ < BAUDRATE * 10 || TIMEOUT_BYTES < 1) begin : g_bad_params
    $error("status_frame_rx: parameter out of range");
  end

  typedef enum logic [1:0] {HUNT, RECEIVE, CHECK} state_e;

  state_e        state_q, state_d;
  logic          rdy_q, rdy_d;
  logic [31:0]   shift_q, shift_d;
  logic [15:0]   crc_q, crc_d;
  logic [6:0]    idx_q, idx_d;
  logic [7:0]    motor_q, motor_d;
  logic [PW-1:0] pay_q, pay_d;
  logic [15:0]   rx_crc_q, rx_crc_d;
  logic          last_q, last_d;
  logic          valid_q, valid_d;
  logic [7:0]    out_motor_q, out_motor_d;
  logic [PW-1:0] out_pay_q, out_pay_d;
  logic [EW-1:0] err_q, err_d;
  logic [15:0]   ok_q, ok_d;
  logic [15:0]   crc_cnt_q, crc_cnt_d;
  logic [15:0]   id_cnt_q, id_cnt_d;
  logic          accept;
  logic          id_ok;

`ifdef STATUS_RX_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_CYCLES = 32'(CLK_FREQ_HZ / BAUDRATE * 10 * TIMEOUT_BYTES);
  localparam logic [7:0]  CODE_TIMEOUT   = 8'd3;
  logic [31:0] timer_q, timer_d;
  logic [15:0] tout_q, tout_d;
`endif

  // One serial CRC step per received byte, MSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h8005;
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Writes a code into the byte of the given motor; out-of-range IDs match nothing.
  function automatic logic [EW-1:0] set_err(input logic [EW-1:0] e, input logic [7:0] id,
                                            input logic [7:0] code);
    logic [EW-1:0] r;
    r = e;
    for (int m = 0; m < NUMBER_OF_MOTORS; m++) begin
      if (id == 8'(m)) r[m*8 +: 8] = code;
    end
    return r;
  endfunction

  assign accept = bus.rx_data_ready & ~rdy_q;
  assign id_ok  = ({1'b0, motor_q} < 9'(NUMBER_OF_MOTORS));

  // Next-state logic: magic hunt, byte collection, and frame validation.
  always_comb begin
    state_d     = state_q;
    rdy_d       = bus.rx_data_ready;
    shift_d     = shift_q;
    crc_d       = crc_q;
    idx_d       = idx_q;
    motor_d     = motor_q;
    pay_d       = pay_q;
    rx_crc_d    = rx_crc_q;
    last_d      = last_q;
    valid_d     = 1'b0;
    out_motor_d = out_motor_q;
    out_pay_d   = out_pay_q;
    err_d       = err_q;
    ok_d        = ok_q;
    crc_cnt_d   = crc_cnt_q;
    id_cnt_d    = id_cnt_q;
`ifdef STATUS_RX_TIMEOUT_EN
    timer_d     = timer_q;
    tout_d      = tout_q;
`endif
    case (state_q)
      HUNT: begin
        if (accept) begin
          shift_d = {shift_q[23:0], bus.rx_data};
          if (shift_d == MAGIC_NUMBER) begin
            state_d = RECEIVE;
            crc_d   = 16'hFFFF;
            idx_d   = 7'd0;
            last_d  = 1'b0;
`ifdef STATUS_RX_TIMEOUT_EN
            timer_d = 32'd0;
`endif
          end
        end
      end
      RECEIVE: begin
        if (last_q) begin
          state_d = CHECK;
          last_d  = 1'b0;
        end else if (accept) begin
          idx_d = idx_q + 7'd1;
`ifdef STATUS_RX_TIMEOUT_EN
          timer_d = 32'd0;
`endif
          if (idx_q == 7'd0) begin
            motor_d = bus.rx_data;
            crc_d   = crc_step(crc_q, bus.rx_data);
          end else if (idx_q <= IDX_LAST_PAY) begin
            pay_d = (pay_q << 8) | PW'(bus.rx_data);
            crc_d = crc_step(crc_q, bus.rx_data);
          end else if (idx_q == IDX_CRC_HI) begin
            rx_crc_d[15:8] = bus.rx_data;
          end else begin
            rx_crc_d[7:0] = bus.rx_data;
            last_d        = 1'b1;
          end
        end
`ifdef STATUS_RX_TIMEOUT_EN
        else begin
          timer_d = timer_q + 32'd1;
          if (timer_d >= TIMEOUT_CYCLES) begin
            state_d = HUNT;
            shift_d = 32'd0;
            timer_d = 32'd0;
            tout_d  = sat_inc(tout_q);
            if (idx_q != 7'd0) err_d = set_err(err_q, motor_q, CODE_TIMEOUT);
          end
        end
`endif
      end
      CHECK: begin
        state_d = HUNT;
        crc_d   = 16'hFFFF;
        idx_d   = 7'd0;
        shift_d = accept ? {24'd0, bus.rx_data} : 32'd0;
        if (shift_d == MAGIC_NUMBER) state_d = RECEIVE;
        if (rx_crc_q == crc_q) begin
          if (id_ok) begin
            valid_d     = 1'b1;
            out_motor_d = motor_q;
            out_pay_d   = pay_q;
            err_d       = set_err(err_q, motor_q, CODE_OK);
            ok_d        = sat_inc(ok_q);
          end else begin
            id_cnt_d = sat_inc(id_cnt_q);
          end
        end else begin
          crc_cnt_d = sat_inc(crc_cnt_q);
          err_d     = set_err(err_q, motor_q, CODE_CRC);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      rdy_q       <= 1'b0;
      shift_q     <= 32'd0;
      crc_q       <= 16'hFFFF;
      idx_q       <= 7'd0;
      motor_q     <= 8'd0;
      pay_q       <= '0;
      rx_crc_q    <= 16'd0;
      last_q      <= 1'b0;
      valid_q     <= 1'b0;
      out_motor_q <= 8'd0;
      out_pay_q   <= '0;
      err_q       <= '0;
      ok_q        <= 16'd0;
      crc_cnt_q   <= 16'd0;
      id_cnt_q    <= 16'd0;
`ifdef STATUS_RX_TIMEOUT_EN
      timer_q     <= 32'd0;
      tout_q      <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      shift_q     <= shift_d;
      crc_q       <= crc_d;
      idx_q       <= idx_d;
      motor_q     <= motor_d;
      pay_q       <= pay_d;
      rx_crc_q    <= rx_crc_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
      out_motor_q <= out_motor_d;
      out_pay_q   <= out_pay_d;
      err_q       <= err_d;
      ok_q        <= ok_d;
      crc_cnt_q   <= crc_cnt_d;
      id_cnt_q    <= id_cnt_d;
`ifdef STATUS_RX_TIMEOUT_EN
      timer_q     <= timer_d;
      tout_q      <= tout_d;
`endif
    end
  end

  assign bus.frame_valid   = valid_q;
  assign bus.frame_motor   = out_motor_q;
  assign bus.frame_payload = out_pay_q;
  assign error_code        = err_q;
  assign ok_count          = ok_q;
  assign crc_err_count     = crc_cnt_q;
  assign id_err_count      = id_cnt_q;
`ifdef STATUS_RX_TIMEOUT_EN
  assign timeout_count     = tout_q;
`else
  assign timeout_count     = 16'd0;
`endif

endmodule

// File: tb/tb_status_frame_rx.sv
// Self-checking bench for status_frame_rx: table-driven frames plus
// hand-written sequences for held ready, back-to-back frames with an
// embedded magic word, inter-byte timeout and mid-frame reset.
module tb_status_frame_rx;

  localparam int NM = 6;
  localparam int PB = 24;
  localparam int TIMEOUT_CYCLES = 50_000_000 / 115200 * 10 * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  status_frame_rx_if #(.PAYLOAD_BYTES(PB)) bus();

  logic [NM*8-1:0] error_code;
  logic [15:0]     ok_count, crc_err_count, id_err_count, timeout_count;

  status_frame_rx #(.NUMBER_OF_MOTORS(NM), .PAYLOAD_BYTES(PB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .error_code    (error_code),
    .ok_count      (ok_count),
    .crc_err_count (crc_err_count),
    .id_err_count  (id_err_count),
    .timeout_count (timeout_count)
  );

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  logic [7:0] pay_buf [PB];

  typedef struct {
    logic [7:0]  id;
    logic [7:0]  start;
    bit          corrupt;
    bit          exp_valid;
    logic [15:0] exp_ok;
    logic [15:0] exp_crc;
    logic [15:0] exp_id;
    logic [7:0]  exp_motor;
    logic [7:0]  exp_pay_start;
    int          err_idx;
    logic [7:0]  err_val;
  } vec_t;

  vec_t vecs [6];
  logic [NM*8-1:0] exp_err;

  // Counts frame_valid strobes, sampled on the falling edge.
  always @(negedge clk) if (bus.frame_valid === 1'b1) strobe_cnt++;

  task automatic check_val(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [15:0] crc_in, input logic [7:0] b);
    logic [15:0] crc;
    crc = crc_in ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) crc = crc[15] ? ((crc << 1) ^ 16'h8005) : (crc << 1);
    return crc;
  endfunction

  function automatic logic [PB*8-1:0] payload_from_start(input logic [7:0] start);
    logic [PB*8-1:0] p;
    for (int k = 0; k < PB; k++) p[(PB-1-k)*8 +: 8] = start + 8'(k);
    return p;
  endfunction

  function automatic logic [PB*8-1:0] payload_from_buf();
    logic [PB*8-1:0] p;
    for (int k = 0; k < PB; k++) p[(PB-1-k)*8 +: 8] = pay_buf[k];
    return p;
  endfunction

  task automatic fill_payload(input logic [7:0] start);
    for (int k = 0; k < PB; k++) pay_buf[k] = start + 8'(k);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk); #1;
    bus.rx_data       = b;
    bus.rx_data_ready = 1'b1;
    repeat (hold) @(posedge clk);
    #1 bus.rx_data_ready = 1'b0;
  endtask

  task automatic send_magic(input int hold);
    send_byte(8'h1C, hold);
    send_byte(8'hEB, hold);
    send_byte(8'h00, hold);
    send_byte(8'hDA, hold);
  endtask

  task automatic applyStimulus(input logic [7:0] id, input bit corrupt, input int hold);
    logic [15:0] c;
    c = 16'hFFFF;
    send_magic(hold);
    send_byte(id, hold);
    c = crc_model(c, id);
    for (int k = 0; k < PB; k++) begin
      send_byte(pay_buf[k], hold);
      c = crc_model(c, pay_buf[k]);
    end
    send_byte(c[15:8], hold);
    send_byte(c[7:0] ^ (corrupt ? 8'h01 : 8'h00), hold);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] eok, input logic [15:0] ecrc,
                             input logic [15:0] eid, input logic [7:0] emotor,
                             input logic [PB*8-1:0] epay);
    check_val({tag, "_ok_count"}, ok_count, eok);
    check_val({tag, "_crc_err_count"}, crc_err_count, ecrc);
    check_val({tag, "_id_err_count"}, id_err_count, eid);
    check_val({tag, "_frame_motor"}, bus.frame_motor, emotor);
    check_val({tag, "_frame_payload"}, bus.frame_payload, epay);
    check_val({tag, "_error_code"}, error_code, exp_err);
  endtask

  // Run-time guard so the bench always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int s0;
    bus.rx_data_ready = 1'b0;
    bus.rx_data       = 8'h00;
    exp_err           = '0;

    vecs[0] = '{8'd2, 8'h01, 1'b0, 1'b1, 16'd1, 16'd0, 16'd0, 8'd2, 8'h01, 2, 8'd0};
    vecs[1] = '{8'd2, 8'h01, 1'b1, 1'b0, 16'd1, 16'd1, 16'd0, 8'd2, 8'h01, 2, 8'd2};
    vecs[2] = '{8'd9, 8'h30, 1'b0, 1'b0, 16'd1, 16'd1, 16'd1, 8'd2, 8'h01, -1, 8'd0};
    vecs[3] = '{8'd5, 8'h40, 1'b0, 1'b1, 16'd2, 16'd1, 16'd1, 8'd5, 8'h40, 5, 8'd0};
    vecs[4] = '{8'd0, 8'h50, 1'b1, 1'b0, 16'd2, 16'd2, 16'd1, 8'd5, 8'h40, 0, 8'd2};
    vecs[5] = '{8'd0, 8'h60, 1'b0, 1'b1, 16'd3, 16'd2, 16'd1, 8'd0, 8'h60, 0, 8'd0};

    repeat (3) @(posedge clk);
    #1;
    check_val("reset_valid", bus.frame_valid, 1'b0);
    check_val("reset_timeout_count", timeout_count, 16'd0);
    checkOutput("reset", 16'd0, 16'd0, 16'd0, 8'd0, '0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 6; v++) begin
      fill_payload(vecs[v].start);
      s0 = strobe_cnt;
      applyStimulus(vecs[v].id, vecs[v].corrupt, 1);
      @(posedge clk); #1;
      check_val($sformatf("v%0d_valid_cycle1", v), bus.frame_valid, 1'b0);
      @(posedge clk); #1;
      check_val($sformatf("v%0d_valid_cycle2", v), bus.frame_valid, vecs[v].exp_valid);
      @(posedge clk); #1;
      check_val($sformatf("v%0d_valid_cycle3", v), bus.frame_valid, 1'b0);
      check_val($sformatf("v%0d_strobes", v), strobe_cnt - s0, vecs[v].exp_valid ? 1 : 0);
      if (vecs[v].err_idx >= 0) exp_err[vecs[v].err_idx*8 +: 8] = vecs[v].err_val;
      checkOutput($sformatf("v%0d", v), vecs[v].exp_ok, vecs[v].exp_crc, vecs[v].exp_id,
                  vecs[v].exp_motor, payload_from_start(vecs[v].exp_pay_start));
    end

    // rx_data_ready held high for three cycles per byte.
    fill_payload(8'h70);
    s0 = strobe_cnt;
    applyStimulus(8'd3, 1'b0, 3);
    repeat (4) @(posedge clk);
    #1;
    check_val("held_strobes", strobe_cnt - s0, 1);
    checkOutput("held", 16'd4, 16'd2, 16'd1, 8'd3, payload_from_start(8'h70));

    // Magic word inside a payload, followed by a second frame with no gap.
    fill_payload(8'h80);
    pay_buf[4] = 8'h1C;
    pay_buf[5] = 8'hEB;
    pay_buf[6] = 8'h00;
    pay_buf[7] = 8'hDA;
    s0 = strobe_cnt;
    applyStimulus(8'd1, 1'b0, 1);
    fill_payload(8'h90);
    applyStimulus(8'd4, 1'b0, 1);
    repeat (4) @(posedge clk);
    #1;
    check_val("b2b_strobes", strobe_cnt - s0, 2);
    checkOutput("b2b", 16'd6, 16'd2, 16'd1, 8'd4, payload_from_start(8'h90));

    // Frame abandoned after ID 1 and ten payload bytes.
    send_magic(1);
    send_byte(8'd1, 1);
    for (int k = 0; k < 10; k++) send_byte(8'hC0 + 8'(k), 1);
`ifdef STATUS_RX_TIMEOUT_EN
    repeat (TIMEOUT_CYCLES - 100) @(posedge clk);
    #1;
    check_val("timeout_not_early", timeout_count, 16'd0);
    repeat (200) @(posedge clk);
    #1;
    check_val("timeout_count", timeout_count, 16'd1);
    exp_err[1*8 +: 8] = 8'd3;
    check_val("timeout_error_code", error_code, exp_err);
    fill_payload(8'hB0);
    applyStimulus(8'd2, 1'b0, 1);
    repeat (4) @(posedge clk);
    #1;
    exp_err[2*8 +: 8] = 8'd0;
    checkOutput("after_timeout", 16'd7, 16'd2, 16'd1, 8'd2, payload_from_start(8'hB0));
`else
    repeat (TIMEOUT_CYCLES + 200) @(posedge clk);
    #1;
    check_val("no_timeout_count", timeout_count, 16'd0);
    checkOutput("no_timeout", 16'd6, 16'd2, 16'd1, 8'd4, payload_from_start(8'h90));
`endif

    // Reset after twelve bytes of a frame, then a clean ID-0 frame.
    send_magic(1);
    send_byte(8'd0, 1);
    for (int k = 0; k < 7; k++) send_byte(8'hE0 + 8'(k), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    exp_err = '0;
    check_val("midreset_timeout_count", timeout_count, 16'd0);
    checkOutput("midreset", 16'd0, 16'd0, 16'd0, 8'd0, '0);
    fill_payload(8'hA0);
    s0 = strobe_cnt;
    applyStimulus(8'd0, 1'b0, 1);
    repeat (4) @(posedge clk);
    #1;
    check_val("post_reset_strobes", strobe_cnt - s0, 1);
    checkOutput("post_reset", 16'd1, 16'd0, 16'd0, 8'd0, payload_from_buf());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/status_frame_rx.md
STATUS_FRAME_RX -- requirements
Module: status_frame_rx

Interface
REQ-001 SHALL have parameter NUMBER_OF_MOTORS, default 6: valid motor IDs are 0..NUMBER_OF_MOTORS-1, range 1..255.
REQ-002 SHALL have parameter PAYLOAD_BYTES, default 24: data bytes following the motor-ID byte, range 1..64.
REQ-003 SHALL have parameter MAGIC_NUMBER, default 32'h1CEB00DA: frame start word, MSB byte first on the wire.
REQ-004 SHALL have parameters CLK_FREQ_HZ (default 50_000_000) and BAUDRATE (default 115200), used only for the timeout.
REQ-005 SHALL have parameter TIMEOUT_BYTES, default 4: allowed inter-byte gap, in 10-bit character times.
REQ-006 CLK  in  1  sole clock; all logic on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 rx_data_ready  in  1  byte-valid from uart_rx; only its rising edge accepts a byte.
REQ-009 rx_data  in  8  received byte, sampled on that rising edge.
REQ-010 frame_valid  out  1  one-cycle strobe marking a validated frame.
REQ-011 frame_motor  out  8  motor ID of the last validated frame.
REQ-012 frame_payload  out  PAYLOAD_BYTES*8  last validated payload; byte 0 in the MSBs.
REQ-013 error_code  out  NUMBER_OF_MOTORS*8  per-motor code; motor m at [8m+7:8m]; codes 0 ok, 2 CRC, 3 timeout.
REQ-014 ok_count, crc_err_count, id_err_count, timeout_count  out  16 each  saturating event counters.

Function
REQ-015 Wire frame: magic (4 bytes), motor ID (1), payload (PAYLOAD_BYTES), CRC (2, high byte first).
REQ-016 CRC: x^16+x^15+x^2+1, init 16'hFFFF, first serial bit D[7], no reflection, no final XOR; covers ID and payload bytes, not magic.
REQ-017 CRC SHALL update incrementally, one step per accepted byte; no multi-byte loop at frame end.
REQ-018 States: HUNT, RECEIVE, CHECK.
REQ-019 HUNT: each accepted byte shifts into a 32-bit register; on a MAGIC_NUMBER match go to RECEIVE, CRC set to FFFF, byte index 0.
REQ-020 RECEIVE: byte index 0 is the ID, 1..PAYLOAD_BYTES are payload, the last two are CRC; magic detection disabled.
REQ-021 RECEIVE to CHECK in the cycle after the final CRC byte is accepted.
REQ-022 CHECK lasts one cycle, then HUNT with the shift register cleared to 0.
REQ-023 CRC match and ID < NUMBER_OF_MOTORS: frame_valid high exactly 2 cycles after the final-byte edge; frame_motor and frame_payload update that cycle; error_code[ID]=0; ok_count+1.
REQ-024 CRC match and ID >= NUMBER_OF_MOTORS: no strobe, outputs unchanged, id_err_count+1.
REQ-025 CRC mismatch: no strobe; crc_err_count+1; error_code[ID]=2 only if ID is valid.
REQ-026 frame_payload and frame_motor SHALL hold their values between strobes; a partial frame never alters them.
REQ-027 Counters saturate at 16'hFFFF and never wrap.
REQ-028 rx_data_ready held high several cycles SHALL accept exactly one byte.
REQ-029 Back-to-back frames with zero idle gap SHALL both be received.

Reset
REQ-030 Reset SHALL force HUNT, clear the shift register, set the CRC to FFFF, set the index to 0, and drive every output (all error_code bytes, all counters, frame_*) to 0.
REQ-031 Reset mid-frame SHALL discard the partial frame, with no counter or error_code change after release.

Configuration
REQ-032 Macro STATUS_RX_TIMEOUT_EN enables the inter-byte timeout.
REQ-033 With the macro defined, RECEIVE counts cycles since the last accepted byte.
REQ-034 When that count reaches CLK_FREQ_HZ/BAUDRATE*10*TIMEOUT_BYTES, the block goes to HUNT, timeout_count+1, and error_code[ID]=3 if an ID was received and is valid.
REQ-035 Without the macro, RECEIVE waits indefinitely, the timeout logic is absent, and timeout_count is tied to 0.

Verification
REQ-036 Magic, ID 2, payload 0x01..0x18, correct CRC -> frame_valid once 2 cycles after last edge; frame_motor=2; frame_payload=0x0102..18; ok_count=1; error_code[2]=0.
REQ-037 Same frame, CRC low byte XOR 0x01 -> no strobe; crc_err_count=1; error_code[2]=2; frame_payload unchanged.
REQ-038 ID 9, NUMBER_OF_MOTORS=6, correct CRC -> no strobe; id_err_count=1; all error_code bytes unchanged.
REQ-039 Payload containing 1C EB 00 DA, then a second valid frame with no gap -> ok_count=2; no resync inside the payload.
REQ-040 Timeout build: ID 1, then 10 bytes, then silence -> after 4 character times HUNT; timeout_count=1; error_code[1]=3. Non-timeout build -> no change.
REQ-041 reset low after byte 12, then a valid ID-0 frame after release -> counters 0 before it, ok_count=1 after it.
